sd_cmd_request_ctrl: RTL and testbench

// Command-issue controller sitting directly upstream of the SD command serialiser, in the SD_CLK domain.

---
 rtl/sd_cmd_request_ctrl_pkg.sv | 48 ++++
 rtl/sd_cmd_request_ctrl_timeout_cnt.sv | 24 ++
 rtl/sd_cmd_request_ctrl.sv | 159 +++++++++++++++
 tb/tb_sd_cmd_request_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_request_ctrl_pkg.sv
// Shared encodings for the SD command-issue controller: FSM states,
// response-type codes, serialiser status bit positions and setting-word builder.
package sd_cmd_request_ctrl_pkg;

  typedef enum logic [6:0] {
    ST_IDLE   = 7'b000_0001,
    ST_SETUP  = 7'b000_0010,
    ST_REQ    = 7'b000_0100,
    ST_EXEC   = 7'b000_1000,
    ST_FINISH = 7'b001_0000,
    ST_DONE   = 7'b010_0000,
    ST_ABORT  = 7'b100_0000
  } state_e;

  typedef enum logic [1:0] {
    RSP_TYPE_NONE     = 2'b00,
    RSP_TYPE_SHORT    = 2'b01,
    RSP_TYPE_LONG     = 2'b10,
    RSP_TYPE_SHORT_NC = 2'b11
  } rsp_type_e;

  localparam int unsigned STAT_FIN = 6;
  localparam int unsigned STAT_CRC = 5;

  localparam logic [6:0]  RSP_SHORT_DEF     = 7'd39;
  localparam logic [6:0]  RSP_LONG_DEF      = 7'd127;
  localparam logic [2:0]  WO_DELAY_DEF      = 3'd7;
  localparam int unsigned ABORT_RST_CYC_DEF = 4;

  // {3'b0, blk_rd, blk_wr, delay, crc_chk, rsp_size}
  function automatic logic [15:0] build_setting(input rsp_type_e  typ,
                                                input logic       rd,
                                                input logic       wr,
                                                input logic [2:0] dly,
                                                input logic [6:0] sz_short,
                                                input logic [6:0] sz_long);
    logic       crc_chk;
    logic [6:0] sz;
    crc_chk = (typ == RSP_TYPE_SHORT) || (typ == RSP_TYPE_LONG);
    case (typ)
      RSP_TYPE_NONE: sz = '0;
      RSP_TYPE_LONG: sz = sz_long;
      default:       sz = sz_short;
    endcase
    return {3'b000, rd, wr, dly, crc_chk, sz};
  endfunction

endpackage

// File: rtl/sd_cmd_request_ctrl_timeout_cnt.sv
// 16-bit saturating cycle counter with synchronous clear/enable and a
// match flag that fires when the count reaches limit-1 (limit 0 disables it).
module sd_cmd_timeout_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] limit_i,
  output logic        match_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign match_o = (limit_i != '0) && (cnt_q == (limit_i - 16'd1));

endmodule

// File: rtl/sd_cmd_request_ctrl.sv
// SD command-issue controller: builds command/setting words, runs the REQ/ACK
// handshake into the serialiser, captures and checks the response, handles timeouts.
module sd_cmd_request_ctrl
  import sd_cmd_request_ctrl_pkg::*;
#(
  parameter logic [6:0]  RSP_SHORT     = RSP_SHORT_DEF,
  parameter logic [6:0]  RSP_LONG      = RSP_LONG_DEF,
  parameter logic [2:0]  WO_DELAY      = WO_DELAY_DEF,
  parameter int unsigned ABORT_RST_CYC = ABORT_RST_CYC_DEF
) (
  input  logic         SD_CLK_IN,
  input  logic         RST_IN,
  input  logic         start_i,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   rsp_type_i,
  input  logic         blk_rd_i,
  input  logic         blk_wr_i,
  input  logic [15:0]  timeout_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [2:0]   err_o,
  output logic [127:0] rsp_o,
  output logic [15:0]  host_setting_o,
  output logic [39:0]  host_cmd_o,
  output logic         host_req_o,
  input  logic         host_ack_i,
  input  logic         host_req_i,
  output logic         host_ack_o,
  input  logic [7:0]   host_status_i,
  input  logic [127:0] host_rsp_i,
  output logic         host_rst_o
);

  state_e       state_q, state_d;
  rsp_type_e    type_q, type_d;
  logic [15:0]  timeout_q, timeout_d;
  logic [15:0]  setting_q, setting_d;
  logic [39:0]  cmd_q, cmd_d;
  logic [127:0] rsp_q, rsp_d;
  logic [2:0]   err_q, err_d;
  logic         crc_valid_q, crc_valid_d;
  logic         ack_q, ack_d;
  logic [3:0]   abort_cnt_q, abort_cnt_d;
  logic         tmo_clr, tmo_en, tmo_match;
  logic         unused_status;

  assign unused_status = ^{host_status_i[7], host_status_i[4:0]};

  assign tmo_clr = (state_q == ST_IDLE) || (state_q == ST_SETUP);
  assign tmo_en  = (state_q == ST_REQ) || (state_q == ST_EXEC) || (state_q == ST_FINISH);

  sd_cmd_timeout_cnt u_timeout_cnt (
    .clk_i   (SD_CLK_IN),
    .rst_i   (RST_IN),
    .clr_i   (tmo_clr),
    .en_i    (tmo_en),
    .limit_i (timeout_q),
    .match_o (tmo_match)
  );

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    timeout_d   = timeout_q;
    setting_d   = setting_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    err_d       = err_q;
    crc_valid_d = crc_valid_q;
    abort_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          type_d      = rsp_type_e'(rsp_type_i);
          timeout_d   = timeout_i;
          cmd_d       = {2'b01, cmd_index_i, cmd_arg_i};
          setting_d   = build_setting(rsp_type_e'(rsp_type_i), blk_rd_i, blk_wr_i,
                                      WO_DELAY, RSP_SHORT, RSP_LONG);
          rsp_d       = '0;
          err_d       = '0;
          crc_valid_d = 1'b0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (host_ack_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (tmo_match)        state_d = ST_ABORT;
        else if (!host_ack_i) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // ack_q holds last cycle's host_req_i here, so it doubles as the edge detector
        if (tmo_match) begin
          state_d = ST_ABORT;
        end else if (host_req_i && !ack_q && host_status_i[STAT_FIN]) begin
          crc_valid_d = host_status_i[STAT_CRC];
          rsp_d       = host_rsp_i;
          state_d     = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (tmo_match) begin
          state_d = ST_ABORT;
        end else if (host_ack_i && !host_req_i) begin
          err_d[1] = setting_q[7] & ~crc_valid_q;
          err_d[2] = (type_q == RSP_TYPE_SHORT) && (rsp_q[125:120] != cmd_q[37:32]);
          state_d  = ST_DONE;
        end
      end
      ST_ABORT: begin
        err_d[0]    = 1'b1;
        abort_cnt_d = abort_cnt_q + 4'd1;
        if (abort_cnt_q == 4'(ABORT_RST_CYC - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ack_d = ((state_d == ST_EXEC) || (state_d == ST_FINISH)) ? host_req_i : 1'b0;
  end

  always_ff @(posedge SD_CLK_IN) begin
    if (RST_IN) begin
      state_q     <= ST_IDLE;
      type_q      <= RSP_TYPE_NONE;
      timeout_q   <= '0;
      setting_q   <= '0;
      cmd_q       <= '0;
      rsp_q       <= '0;
      err_q       <= '0;
      crc_valid_q <= 1'b0;
      ack_q       <= 1'b0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      timeout_q   <= timeout_d;
      setting_q   <= setting_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      err_q       <= err_d;
      crc_valid_q <= crc_valid_d;
      ack_q       <= ack_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);
  assign err_o          = err_q;
  assign rsp_o          = rsp_q;
  assign host_setting_o = setting_q;
  assign host_cmd_o     = cmd_q;
  assign host_req_o     = (state_q == ST_REQ);
  assign host_ack_o     = ack_q;
  assign host_rst_o     = (state_q == ST_ABORT);

endmodule

// File: tb/tb_sd_cmd_request_ctrl.sv
// Directed bench for sd_cmd_request_ctrl: a hand-driven serialiser stub steps
// each command through the handshake and results are checked against fixed values.
module tb_sd_cmd_request_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [5:0]   cmd_index_i;
  logic [31:0]  cmd_arg_i;
  logic [1:0]   rsp_type_i;
  logic         blk_rd_i, blk_wr_i;
  logic [15:0]  timeout_i;
  logic         busy_o, done_o;
  logic [2:0]   err_o;
  logic [127:0] rsp_o;
  logic [15:0]  host_setting_o;
  logic [39:0]  host_cmd_o;
  logic         host_req_o, host_ack_i, host_req_i, host_ack_o, host_rst_o;
  logic [7:0]   host_status_i;
  logic [127:0] host_rsp_i;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [127:0] RSP_IDX17 = 128'h1100_0000_0000_0000_0000_0000_0000_0901;
  localparam logic [127:0] RSP_IDX3  = 128'h0300_0000_0000_0000_0000_0000_0000_0901;
  localparam logic [127:0] RSP_LONGV = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;

  always #5 clk = ~clk;

  sd_cmd_request_ctrl dut (
    .SD_CLK_IN      (clk),
    .RST_IN         (rst),
    .start_i        (start_i),
    .cmd_index_i    (cmd_index_i),
    .cmd_arg_i      (cmd_arg_i),
    .rsp_type_i     (rsp_type_i),
    .blk_rd_i       (blk_rd_i),
    .blk_wr_i       (blk_wr_i),
    .timeout_i      (timeout_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .rsp_o          (rsp_o),
    .host_setting_o (host_setting_o),
    .host_cmd_o     (host_cmd_o),
    .host_req_o     (host_req_o),
    .host_ack_i     (host_ack_i),
    .host_req_i     (host_req_i),
    .host_ack_o     (host_ack_o),
    .host_status_i  (host_status_i),
    .host_rsp_i     (host_rsp_i),
    .host_rst_o     (host_rst_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Start a command and walk it through SETUP and REQ into EXEC.
  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                       input logic rd, input logic wr, input logic [15:0] tmo,
                       input logic [39:0] exp_cmd, input logic [15:0] exp_set);
    cmd_index_i = idx; cmd_arg_i = arg; rsp_type_i = typ;
    blk_rd_i = rd; blk_wr_i = wr; timeout_i = tmo;
    host_ack_i = 1'b1; host_req_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("setup_busy", busy_o, 1'b1);
    chk("host_cmd", host_cmd_o, exp_cmd);
    chk("host_setting", host_setting_o, exp_set);
    chk("err_cleared", err_o, 3'b000);
    chk("rsp_cleared", rsp_o, '0);
    tick();
    chk("req_high", host_req_o, 1'b1);
    host_ack_i = 1'b0;
    tick();
    chk("req_low_exec", host_req_o, 1'b0);
  endtask

  // Serialiser returns its final status strobe, then goes idle.
  task automatic respond(input logic [127:0] rsp, input logic [7:0] status);
    host_rsp_i = rsp; host_status_i = status; host_req_i = 1'b1;
    tick();
    chk("ack_mirror", host_ack_o, 1'b1);
    host_req_i = 1'b0; host_ack_i = 1'b1;
    tick();
    chk("done_pulse", done_o, 1'b1);
    chk("done_ack_low", host_ack_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int r;
    int reqcnt;
    rst = 1'b1; start_i = 1'b0; cmd_index_i = '0; cmd_arg_i = '0; rsp_type_i = '0;
    blk_rd_i = 1'b0; blk_wr_i = 1'b0; timeout_i = '0; host_ack_i = 1'b1;
    host_req_i = 1'b0; host_status_i = '0; host_rsp_i = '0;
    tick(); tick();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_outs", {err_o, host_req_o, host_ack_o, host_rst_o}, '0);
    chk("rst_words", {host_setting_o, host_cmd_o}, '0);
    chk("rst_rsp", rsp_o, '0);
    rst = 1'b0;
    tick();

    // Short response, with a non-final strobe first
    issue(6'd17, 32'h0000_0200, 2'b01, 1'b0, 1'b0, 16'd0, 40'h51_0000_0200, 16'h07A7);
    host_status_i = 8'h04; host_req_i = 1'b1;
    tick();
    chk("stray_ack", host_ack_o, 1'b1);
    chk("stray_busy", busy_o, 1'b1);
    host_req_i = 1'b0;
    tick();
    chk("stray_ack_drop", host_ack_o, 1'b0);
    respond(RSP_IDX17, 8'h60);
    chk("short_err", err_o, 3'b000);
    chk("short_rsp", rsp_o, RSP_IDX17);
    tick();
    chk("done_one_cycle", done_o, 1'b0);
    chk("idle_busy", busy_o, 1'b0);
    chk("cmd_stable", host_cmd_o, 40'h51_0000_0200);

    // Long response with CRC invalid
    issue(6'd2, 32'hCAFE_0001, 2'b10, 1'b1, 1'b0, 16'd0, 40'h42_CAFE_0001, 16'h17FF);
    respond(RSP_LONGV, 8'h40);
    chk("long_err", err_o, 3'b010);
    chk("long_rsp", rsp_o, RSP_LONGV);
    tick();

    // No-response command
    issue(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 16'd0, 40'h40_0000_0000, 16'h0700);
    respond(RSP_IDX3, 8'h44);
    chk("none_err", err_o, 3'b000);
    tick();

    // Index mismatch on checked short response
    issue(6'd17, 32'h0000_0200, 2'b01, 1'b0, 1'b0, 16'd0, 40'h51_0000_0200, 16'h07A7);
    respond(RSP_IDX3, 8'h60);
    chk("idx_err", err_o, 3'b100);
    tick();
    chk("err_held", err_o, 3'b100);

    // Same response, unchecked short type: no index or CRC error
    issue(6'd17, 32'h0000_0200, 2'b11, 1'b0, 1'b1, 16'd0, 40'h51_0000_0200, 16'h0F27);
    respond(RSP_IDX3, 8'h40);
    chk("nc_err", err_o, 3'b000);
    tick();

    // Timeout: serialiser never answers
    issue(6'd17, 32'h0000_0200, 2'b01, 1'b0, 1'b0, 16'd20, 40'h51_0000_0200, 16'h07A7);
    n = 1;
    while (!host_rst_o && n < 40) begin
      tick();
      n++;
    end
    chk("abort_cycle", n, 20);
    r = 0;
    while (host_rst_o && r < 10) begin
      tick();
      r++;
    end
    chk("abort_rst_len", r, 4);
    chk("abort_done", done_o, 1'b1);
    chk("abort_err", err_o, 3'b001);
    chk("abort_rsp", rsp_o, '0);
    tick();

    // start held through busy, then reset mid-EXEC
    cmd_index_i = 6'd8; cmd_arg_i = 32'h0000_01AA; rsp_type_i = 2'b01; timeout_i = '0;
    host_ack_i = 1'b1; start_i = 1'b1; reqcnt = 0;
    tick();
    tick();
    if (host_req_o) reqcnt++;
    host_ack_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (host_req_o) reqcnt++;
    end
    chk("req_once", reqcnt, 1);
    chk("held_busy", busy_o, 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_outs", {done_o, err_o, host_req_o, host_ack_o, host_rst_o}, '0);
    chk("midrst_words", {host_setting_o, host_cmd_o}, '0);
    rst = 1'b0; start_i = 1'b0; host_ack_i = 1'b1;
    tick(); tick();
    chk("post_rst_idle", {busy_o, done_o, host_req_o}, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
